// File: rtl/fixed_point_pkg.sv
// Shared Q16.16 fixed-point package: format constants and the divider FSM
// state type. The combinational fixed-point operator uses the same package.
package fixed_point_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;

    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
    localparam logic [31:0] Q_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/fixed_point_divider_if.sv
// Request/result bundle of the fixed-point divider. The master side issues
// operands with a start pulse; the slave side (the divider) returns the
// quotient with a one-cycle valid pulse.
interface fixed_point_divider_if;
    import fixed_point_pkg::*;

    logic              i_start;
    logic [DATA_W-1:0] din_1;
    logic [DATA_W-1:0] din_2;
    logic [DATA_W-1:0] dout;
    logic              o_valid;
    logic              o_busy;
    logic              o_div_zero;

    modport master (
        output i_start, din_1, din_2,
        input  dout, o_valid, o_busy, o_div_zero
    );

    modport slave (
        input  i_start, din_1, din_2,
        output dout, o_valid, o_busy, o_div_zero
    );

endinterface

// File: rtl/fixed_point_sign_sat.sv
// Sign restore and saturation for a wide unsigned magnitude. Produces a
// DATA_W two's-complement value clamped to [Q_MIN, Q_MAX]. Kept standalone so
// the multiplier path can reuse it with its own magnitude width.
module fixed_point_sign_sat #(
    parameter int MAG_W = fixed_point_pkg::DATA_W + fixed_point_pkg::FRAC_BITS
) (
    input  logic [MAG_W-1:0]                  mag,
    input  logic                              neg,
    output logic [fixed_point_pkg::DATA_W-1:0] q_out
);
    import fixed_point_pkg::*;

    // Largest positive magnitude and largest negative magnitude (one more).
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'({(DATA_W-1){1'b1}});
    localparam logic [MAG_W-1:0] NEG_LIM = POS_LIM + MAG_W'(1);

    logic [DATA_W-1:0] mag_low;

    // Clamp the magnitude to the signed range, then restore the sign.
    always_comb begin
        mag_low = mag[DATA_W-1:0];
        q_out   = mag_low;
        if (neg) begin
            q_out = (mag > NEG_LIM) ? Q_MIN : (-mag_low);
        end else begin
            q_out = (mag > POS_LIM) ? Q_MAX : mag_low;
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q16.16 divider, radix-2 restoring, one quotient bit per
// clock. Accepts on a start pulse in IDLE, iterates 48 times in CALC and
// registers the sign-restored, saturated quotient in FIX.
// Optional build macro: FIXED_POINT_DIV_ROUND_EN selects round-to-nearest
// (ties away from zero) instead of truncation toward zero.
module fixed_point_divider (
    input  logic                   i_clk,
    input  logic                   i_rst,
    fixed_point_divider_if.slave   bus
);
    import fixed_point_pkg::*;

    localparam int DVD_W = DATA_W + FRAC_BITS;
    localparam int CNT_W = $clog2(DVD_W);

    div_state_t        state_reg;
    logic [DVD_W-1:0]  dvd_reg;      // dividend bits still to be brought in
    logic [DVD_W-1:0]  quo_reg;      // quotient magnitude
    logic [DATA_W-1:0] dvs_reg;      // divisor magnitude
    logic [DATA_W-1:0] rem_reg;      // partial remainder, always < divisor
    logic [CNT_W-1:0]  cnt_reg;
    logic              sign_reg;     // quotient is negative
    logic              dvd_neg_reg;  // dividend is negative (divide-by-zero result)
    logic              dz_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              dz_out_reg;

    logic [DATA_W-1:0] abs_1;
    logic [DATA_W-1:0] abs_2;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;
    logic              fits;
    logic [DVD_W-1:0]  mag_final;
    logic [DATA_W-1:0] sat_q;

    // |x| of the most negative value wraps to itself, which is the correct
    // unsigned magnitude 2^(DATA_W-1).
    assign abs_1 = bus.din_1[DATA_W-1] ? (-bus.din_1) : bus.din_1;
    assign abs_2 = bus.din_2[DATA_W-1] ? (-bus.din_2) : bus.din_2;

    // One restoring step. The remainder stays below the divisor, so after
    // the shift it fits DATA_W+1 bits and the borrow bit of the difference
    // says whether the divisor fits.
    assign rem_shift = {rem_reg, dvd_reg[DVD_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_reg};
    assign fits      = ~rem_diff[DATA_W];

`ifdef FIXED_POINT_DIV_ROUND_EN
    logic round_up;
    // Remainder at least half the divisor: round the magnitude up.
    assign round_up  = ({rem_reg, 1'b0} >= {1'b0, dvs_reg});
    assign mag_final = quo_reg + DVD_W'(round_up);
`else
    assign mag_final = quo_reg;
`endif

    fixed_point_sign_sat #(.MAG_W(DVD_W)) u_sign_sat (
        .mag   (mag_final),
        .neg   (sign_reg),
        .q_out (sat_q)
    );

    // Divider FSM: accept, iterate, then register the result with a valid pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            dvd_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            sign_reg    <= 1'b0;
            dvd_neg_reg <= 1'b0;
            dz_reg      <= 1'b0;
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            dz_out_reg  <= 1'b0;
        end else begin
            valid_reg  <= 1'b0;
            dz_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.i_start) begin
                        sign_reg    <= bus.din_1[DATA_W-1] ^ bus.din_2[DATA_W-1];
                        dvd_neg_reg <= bus.din_1[DATA_W-1];
                        dvd_reg     <= {abs_1, {FRAC_BITS{1'b0}}};
                        dvs_reg     <= abs_2;
                        rem_reg     <= '0;
                        quo_reg     <= '0;
                        cnt_reg     <= CNT_W'(DVD_W - 1);
                        busy_reg    <= 1'b1;
                        dz_reg      <= (bus.din_2 == '0);
                        state_reg   <= (bus.din_2 == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    dvd_reg <= {dvd_reg[DVD_W-2:0], 1'b0};
                    rem_reg <= fits ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                    quo_reg <= {quo_reg[DVD_W-2:0], fits};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (dz_reg) begin
                        dout_reg <= dvd_neg_reg ? Q_MIN : Q_MAX;
                    end else begin
                        dout_reg <= sat_q;
                    end
                    valid_reg  <= 1'b1;
                    dz_out_reg <= dz_reg;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.o_valid    = valid_reg;
    assign bus.o_busy     = busy_reg;
    assign bus.o_div_zero = dz_out_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Testbench for fixed_point_divider: directed vectors, randomized operands
// against an integer-arithmetic reference, divide-by-zero, ignored starts,
// reset abort and back-to-back issue.
module tb_fixed_point_divider;
    import fixed_point_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fixed_point_divider_if bus();

    fixed_point_divider dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact rational arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, n, d, mag, res;
        logic [63:0] res_bits;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return (sa >= 0) ? Q_MAX : Q_MIN;
        n   = ((sa < 0) ? -sa : sa) * (longint'(1) << FRAC_BITS);
        d   = (sb < 0) ? -sb : sb;
        mag = n / d;
`ifdef FIXED_POINT_DIV_ROUND_EN
        if (2 * (n % d) >= d) mag = mag + 1;
`endif
        res = ((sa < 0) != (sb < 0)) ? -mag : mag;
        if (res > 64'sd2147483647) return Q_MAX;
        if (res < -64'sd2147483648) return Q_MIN;
        res_bits = res;
        return res_bits[31:0];
    endfunction

    // Issue one division and wait (bounded) for its result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] got, output logic dzf, output int lat,
                           output logic busy_acc, output logic busy_val);
        @(negedge clk);
        bus.din_1   = a;
        bus.din_2   = b;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.din_1   = $urandom;
        bus.din_2   = $urandom;
        busy_acc    = bus.o_busy;
        lat         = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                lat = c;
                break;
            end
        end
        got      = bus.dout;
        dzf      = bus.o_div_zero;
        busy_val = bus.o_busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.din_1 = $urandom;
        bus.din_2 = $urandom;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold: dout=%h valid=%b busy=%b dz=%b required all 0",
                     bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_release: dout=%h valid=%b busy=%b dz=%b required all 0",
                     bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_directed();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] ve [7];
        logic [31:0] got;
        logic dzf, ba, bv;
        int lat, exp_lat;
        va[0] = 32'h0001_0000; vb[0] = 32'h0000_8000; ve[0] = 32'h0002_0000;
        va[1] = 32'hFFFF_0000; vb[1] = 32'h0000_8000; ve[1] = 32'hFFFE_0000;
        va[2] = 32'h0001_0000; vb[2] = 32'hFFFF_8000; ve[2] = 32'hFFFE_0000;
`ifdef FIXED_POINT_DIV_ROUND_EN
        va[3] = 32'h0002_0000; vb[3] = 32'h0003_0000; ve[3] = 32'h0000_AAAB;
`else
        va[3] = 32'h0002_0000; vb[3] = 32'h0003_0000; ve[3] = 32'h0000_AAAA;
`endif
        va[4] = 32'h7FFF_0000; vb[4] = 32'h0000_0100; ve[4] = 32'h7FFF_FFFF;
        va[5] = 32'h8000_0000; vb[5] = 32'h0000_0100; ve[5] = 32'h8000_0000;
        va[6] = 32'h0000_0000; vb[6] = 32'hFFFF_0000; ve[6] = 32'h0000_0000;
        for (int i = 0; i < 7; i++) begin
            run_div(va[i], vb[i], got, dzf, lat, ba, bv);
            exp_lat = 49;
            $display("directed[%0d]: %h / %h -> dout=%h lat=%0d dz=%b", i, va[i], vb[i], got, lat, dzf);
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL directed_dout[%0d]: got %h required %h", i, got, ve[i]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, exp_lat);
            end
            checks++;
            if ({dzf, ba, bv} !== 3'b010) begin
                errors++;
                $display("FAIL directed_flags[%0d]: dz/busy_acc/busy_val=%b%b%b required 010", i, dzf, ba, bv);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] va [3];
        logic [31:0] got;
        logic dzf, ba, bv;
        int lat;
        va[0] = 32'hFFFF_0000;
        va[1] = 32'h0001_0000;
        va[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], 32'h0, got, dzf, lat, ba, bv);
            $display("div_zero[%0d]: %h / 0 -> dout=%h lat=%0d dz=%b", i, va[i], got, lat, dzf);
            checks++;
            if (got !== ref_div(va[i], 32'h0)) begin
                errors++;
                $display("FAIL dz_dout[%0d]: got %h required %h", i, got, ref_div(va[i], 32'h0));
            end
            checks++;
            if (lat != 1 || dzf !== 1'b1 || bv !== 1'b0) begin
                errors++;
                $display("FAIL dz_flags[%0d]: lat=%0d dz=%b busy=%b required lat=1 dz=1 busy=0", i, lat, dzf, bv);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.o_valid !== 1'b0 || bus.o_div_zero !== 1'b0 || bus.dout !== got) begin
                errors++;
                $display("FAIL dz_pulse[%0d]: valid=%b dz=%b dout=%h required 0 0 %h",
                         i, bus.o_valid, bus.o_div_zero, bus.dout, got);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] special [7];
        logic [31:0] a, b, exp_q, got;
        logic dzf, ba, bv;
        int lat;
        special[0] = 32'h0000_0000; special[1] = 32'h8000_0000; special[2] = 32'h7FFF_FFFF;
        special[3] = 32'hFFFF_FFFF; special[4] = 32'h0001_0000; special[5] = 32'hFFFF_0000;
        special[6] = 32'h0000_0001;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = $urandom_range(1, 32'h0003_FFFF); end
                2: begin a = $urandom_range(0, 32'h0004_0000); b = $urandom; end
                default: begin a = special[$urandom_range(0, 6)]; b = special[$urandom_range(1, 6)]; end
            endcase
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            exp_q = ref_div(a, b);
            run_div(a, b, got, dzf, lat, ba, bv);
            $display("random[%0d]: %h / %h -> dout=%h exp=%h lat=%0d", i, a, b, got, exp_q, lat);
            checks++;
            if (got !== exp_q || dzf !== (b == 32'h0)) begin
                errors++;
                $display("FAIL random_dout[%0d]: got %h dz=%b required %h dz=%b", i, got, dzf, exp_q, (b == 32'h0));
            end
            checks++;
            if (lat != ((b == 32'h0) ? 1 : 49)) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d required %0d", i, lat, (b == 32'h0) ? 1 : 49);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, got;
        logic dzf, ba, bv;
        int lat;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom_range(1, 32'h00FF_FFFF);
            run_div(a, b, got, dzf, lat, ba, bv);
            $display("back_to_back[%0d]: %h / %h -> dout=%h lat=%0d", i, a, b, got, lat);
            checks++;
            if (got !== ref_div(a, b) || lat != 49 || ba !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: dout=%h lat=%0d busy_acc=%b required %h 49 1",
                         i, got, lat, ba, ref_div(a, b));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic seen;
        logic [31:0] got;
        @(negedge clk);
        bus.din_1 = 32'h0003_0000;
        bus.din_2 = 32'h0002_0000;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                @(negedge clk);
                bus.din_1 = 32'h7FFF_0000;
                bus.din_2 = 32'h0000_0100;
                bus.i_start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_valid) begin
                lat = c;
                break;
            end
        end
        got = bus.dout;
        $display("ignore_start: dout=%h lat=%0d", got, lat);
        checks++;
        if (got !== ref_div(32'h0003_0000, 32'h0002_0000) || lat != 49) begin
            errors++;
            $display("FAIL ignore_start: dout=%h lat=%0d required %h 49",
                     got, lat, ref_div(32'h0003_0000, 32'h0002_0000));
        end
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.o_valid || bus.o_busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_extra: valid/busy activity seen=%b required 0", seen);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        logic [31:0] got;
        logic dzf, ba, bv;
        int lat;
        @(negedge clk);
        bus.din_1 = Q_ONE;
        bus.din_2 = 32'h0000_8000;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs: dout=%h valid=%b busy=%b dz=%b required all 0",
                     bus.dout, bus.o_valid, bus.o_busy, bus.o_div_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.o_valid || bus.o_busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid: activity seen=%b required 0", seen);
        end
        run_div(Q_ONE, 32'h0000_8000, got, dzf, lat, ba, bv);
        $display("reset_abort: post-reset 1.0/0.5 -> dout=%h lat=%0d", got, lat);
        checks++;
        if (got !== 32'h0002_0000 || lat != 49) begin
            errors++;
            $display("FAIL abort_restart: dout=%h lat=%0d required 00020000 49", got, lat);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.din_1 = '0;
        bus.din_2 = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential signed Q16.16 divider: the inverse of the combinational fixed-point add/multiply operator. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring division, one quotient bit per clock. It returns a saturated, truncated quotient with a one-cycle valid pulse. It sits beside the fixed-point operator and shares its 32-bit Q16.16 data format (0x00010000 = 1.0).

## Interface
- DATA_W, 32, operand/result width (two's complement)
- FRAC_BITS, 16, fractional bits (Q(DATA_W-FRAC_BITS).FRAC_BITS)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  request; sampled only in IDLE
- din_1  in  DATA_W  dividend (signed)
- din_2  in  DATA_W  divisor (signed)
- dout  out  DATA_W  quotient, held until next result
- o_valid  out  1  one-cycle pulse: dout updated this cycle
- o_busy  out  1  high from accept edge until the result edge
- o_div_zero  out  1  qualifies o_valid; divisor was zero

## Operation
- States: IDLE, CALC, FIX.
- IDLE, i_start=1: latch sign = din_1[MSB]^din_2[MSB], |din_1|, |din_2|. Build the dividend |din_1|<<FRAC_BITS (DATA_W+FRAC_BITS = 48 bits). Set the iteration counter to 47. Go to CALC; if din_2==0, set dz and go straight to FIX.
- CALC: each edge, shift the remainder left by 1 and bring in the next dividend bit. If rem ≥ |divisor|, subtract it and shift in quotient bit 1; otherwise shift in 0. At counter 0, go to FIX.
- FIX, one edge: dout gets the result, o_valid=1, o_div_zero=dz, state returns to IDLE. The result is:
  - |q| truncated toward zero.
  - Positive result: saturate to 0x7FFFFFFF if |q| > 2^31-1.
  - Negative result: saturate to 0x80000000 if |q| > 2^31; otherwise negate.
  - Divide by zero: dout = 0x7FFFFFFF if din_1 ≥ 0, else 0x80000000.
- Zero dividend gives dout 0x00000000, never -0 issues.
- i_start while o_busy=1 is ignored; operands are not re-latched.
- din_1/din_2 are don't-care except on the accept edge.

## Timing
- Reset values: dout=0, o_valid=0, o_busy=0, o_div_zero=0, state IDLE, all datapath regs 0.
- i_rst mid-CALC/FIX aborts immediately with no o_valid. The first start after reset release is accepted normally.
- Accept edge N. CALC iterations occur on edges N+1..N+48. Result registered on edge N+49, so o_valid is high for exactly the cycle after N+49.
- Latency is DATA_W+FRAC_BITS+1 = 49 cycles.
- Divide by zero: result on edge N+1 (latency 1).
- o_busy is 1 from edge N to edge N+49; it is 0 in the o_valid cycle.
- The next start is sampled earliest at edge N+50. Back-to-back throughput is one division per 50 cycles.
- o_div_zero is a registered pulse aligned with o_valid and cleared on the following edge.

## Configuration
- FIXED_POINT_DIV_ROUND_EN defined: round to nearest, ties away from zero. Add 1 to |q| when 2·rem ≥ |divisor|, before saturation.
- Latency and ports are unchanged.
- Undefined: truncation toward zero.

## Structure
- Shared package fixed_point_pkg holds:
  - DATA_W and FRAC_BITS defaults
  - Q_MAX = 32'h7FFFFFFF, Q_MIN = 32'h80000000, Q_ONE = 32'h00010000
  - the div_state_t enum (IDLE, CALC, FIX)
- The fixed-point operator reuses the same package.
- One sub-module, fixed_point_sign_sat: combinational magnitude/sign restore and saturation. Input is the unsigned |q| plus sign; output is DATA_W signed. The saturation logic is kept separate so it can be reused by the multiplier path.

## Test plan
- din_1=0x00010000, din_2=0x00008000, start pulse -> dout=0x00020000, o_valid exactly 49 cycles after the accept edge, o_div_zero=0.
- din_1=0xFFFF0000 (-1.0), din_2=0x00008000 -> dout=0xFFFE0000; and din_1=0x00010000, din_2=0xFFFF8000 -> 0xFFFE0000.
- din_1=0x00020000, din_2=0x00030000 -> dout=0x0000AAAA (truncate); 0x0000AAAB with FIXED_POINT_DIV_ROUND_EN.
- din_1=0x7FFF0000, din_2=0x00000100 -> 0x7FFFFFFF; din_1=0x80000000, din_2=0x00000100 -> 0x80000000.
- din_1=0xFFFF0000, din_2=0 -> dout=0x80000000, o_div_zero=1, o_valid 1 cycle after accept.
- Start with new operands mid-CALC is ignored (the original result is returned). Asserting i_rst at cycle 20 of CALC gives all outputs 0 and no o_valid; a subsequent 1.0/0.5 returns 0x00020000.
